// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE or DONE
//   dividend     numerator, captured on accepted start
//   divisor      denominator, captured on accepted start
//   busy         high while iterating (RUN)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient, held until the next op completes
//   remainder    registered remainder, same hold rule
//   div_by_zero  registered flag for the last completed operation
// Optional: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // partial remainder never reaches the divisor, so its top bit is always zero and is not stored
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic dbz_q, dbz_d;
    logic [WIDTH:0] r_sh, diff;
    logic [WIDTH-1:0] q_step, r_fin, a_mag, b_mag, q_res, r_res;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d;
`endif
    assign r_sh   = {r_q, q_q[WIDTH-1]};
    assign diff   = r_sh - {1'b0, dvsr_q};
    // top bit of diff set means the trial subtraction borrowed: restore
    assign q_step = {q_q[WIDTH-2:0], ~diff[WIDTH]};
    assign r_fin  = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
`ifdef SEQ_DIVIDER_SIGNED_EN
    // most-negative magnitude wraps to itself, which is its correct unsigned value
    assign a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag  = divisor[WIDTH-1] ? -divisor : divisor;
    assign q_res  = qneg_q ? -q_step : q_step;
    assign r_res  = rneg_q ? -r_fin : r_fin;
`else
    assign a_mag  = dividend;
    assign b_mag  = divisor;
    assign q_res  = q_step;
    assign r_res  = r_fin;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        if (state_q == RUN) begin
            r_d   = r_fin;
            q_d   = q_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                state_d = DONE;
                quot_d  = q_res;
                rem_d   = r_res;
                dbz_d   = 1'b0;
            end
        end else if (start) begin
            if (divisor == '0) begin
                state_d = DONE;
                quot_d  = '1;
                rem_d   = dividend;
                dbz_d   = 1'b1;
            end else begin
                state_d = RUN;
                dvsr_d  = b_mag;
                q_d     = a_mag;
                r_d     = '0;
                cnt_d   = CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
                qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                rneg_d  = dividend[WIDTH-1];
`endif
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized self-checking bench for seq_divider against an arithmetic model.
module tb_seq_divider;
    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;
    logic clk = 1'b0;
    logic rst_n, start, busy, done, div_by_zero;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    int n_tests = 0;
    int n_fail = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input int a, input int b, output int q, output int r, output int z);
        int sa, sb;
        z = (b == 0) ? 1 : 0;
        if (b == 0) begin
            q = MASK;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
            sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
`else
            sa = a;
            sb = b;
`endif
            q = (sa / sb) & MASK;
            r = (sa % sb) & MASK;
        end
    endfunction

    // call at a negedge; returns at the negedge where done is observed
    task automatic run_op(input int a, input int b, input bit noise);
        int cyc, bc, eq, er, ez;
        logic [W-1:0] pq, pr;
        bit chg;
        pq = quotient;
        pr = remainder;
        chg = 0;
        bc = 0;
        start = 1'b1;
        dividend = W'(a);
        divisor = W'(b);
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 40) begin
            if (busy) bc++;
            if (quotient !== pq || remainder !== pr) chg = 1;
            start = (noise && busy) ? 1'($urandom) : 1'b0;
            if (noise) begin
                dividend = W'($urandom);
                divisor = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        model(a, b, eq, er, ez);
        check("latency", cyc, (b == 0) ? 1 : W + 1);
        check("busy_cycles", bc, (b == 0) ? 0 : W);
        check("busy_at_done", busy, 0);
        check("hold_mid_op", chg, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
`ifndef SEQ_DIVIDER_SIGNED_EN
        if (b != 0) begin
            check("identity", quotient * b + remainder, a);
            check("rem_lt_div", (remainder < b) ? 1 : 0, 1);
        end
`endif
    endtask

    task automatic pulse_end;
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(13, 3, 0); pulse_end();
        run_op(7, 0, 0); pulse_end();
        run_op(3, 5, 0); pulse_end();
        run_op(15, 1, 0); pulse_end();
        run_op(9, 2, 1);
        run_op(14, 4, 0); pulse_end();
        run_op(7, 0, 0); pulse_end();
        start = 1'b1;
        dividend = 4'd12;
        divisor = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("abort_no_done", seen, 0);
        run_op(12, 5, 0); pulse_end();
`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(9, 2, 0); pulse_end();
        run_op(7, 14, 0); pulse_end();
        run_op(8, 15, 0); pulse_end();
`endif
        for (int a = 0; a <= MASK; a++)
            for (int b = 0; b <= MASK; b++)
                run_op(a, b, 0);
        pulse_end();
        for (int i = 0; i < 200; i++) begin
            run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1);
            if ($urandom_range(0, 2) == 0) pulse_end();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
